// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 4-digit 7-segment scan scheduler.
// Fixed 16-tick slots, blanking lead-in, PWM brightness, skips disabled digits.
module disp_scan_ctrl #(
   parameter int DIV         = 5,
   parameter int BLANK_TICKS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] digit0,
   input  logic [7:0] digit1,
   input  logic [7:0] digit2,
   input  logic [7:0] digit3,
   input  logic [3:0] digit_en,
   input  logic [3:0] brightness,
   output logic [3:0] LEDSEL,
   output logic [7:0] LEDOUT,
   output logic [1:0] scan_idx,
   output logic       frame_done
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
   localparam logic [4:0] BLANK = 5'(BLANK_TICKS);

   logic [PW-1:0] pre;
   logic          tick;
   logic [3:0]    t;
   logic [3:0]    t_nxt;
   logic [7:0]    snap;
   logic [7:0]    snap_nxt;
   logic [1:0]    idx_adv;
   logic [1:0]    idx_nxt;
   logic [1:0]    cand;
   logic          found;
   logic [7:0]    digit_sel;
   logic          fd_nxt;
   logic          on;
   logic [4:0]    tn5;
   logic [3:0]    sel_nxt;
   logic [7:0]    out_nxt;

   assign tick = (pre == PRE_MAX);

   // Prescaler: one scan tick every DIV clocks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre <= '0;
      end else if (tick) begin
         pre <= '0;
      end else begin
         pre <= pre + PW'(1);
      end
   end

   // Find the next enabled digit in circular order; self is last choice.
   always_comb begin
      idx_adv = scan_idx;
      found   = 1'b0;
      cand    = scan_idx;
      for (int k = 1; k <= 4; k++) begin
         cand = scan_idx + 2'(k);
         if (!found && digit_en[cand]) begin
            idx_adv = cand;
            found   = 1'b1;
         end
      end
   end

   // Pattern of the digit about to be scanned.
   always_comb begin
      digit_sel = 8'hFF;
      case (idx_adv)
         2'd0:    digit_sel = digit0;
         2'd1:    digit_sel = digit1;
         2'd2:    digit_sel = digit2;
         default: digit_sel = digit3;
      endcase
   end

   // Next slot state and drive decision from the post-tick (idx, t).
   always_comb begin
      t_nxt    = t + 4'd1;
      idx_nxt  = scan_idx;
      snap_nxt = snap;
      fd_nxt   = 1'b0;
      if (t == 4'hF) begin
         t_nxt    = 4'd0;
         idx_nxt  = idx_adv;
         snap_nxt = digit_sel;
         fd_nxt   = (|digit_en) && (idx_adv <= scan_idx);
      end
      tn5 = {1'b0, t_nxt};
      on  = digit_en[idx_nxt]
            && (tn5 >= BLANK)
            && ((tn5 - BLANK) < {1'b0, brightness});
      sel_nxt = 4'hF;
      out_nxt = 8'hFF;
      if (on) begin
         sel_nxt = ~(4'b0001 << idx_nxt);
         out_nxt = snap_nxt;
      end
   end

   // Slot state and registered outputs, advanced only on scan ticks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t          <= 4'd0;
         scan_idx   <= 2'd0;
         snap       <= 8'hFF;
         LEDSEL     <= 4'hF;
         LEDOUT     <= 8'hFF;
         frame_done <= 1'b0;
      end else begin
         frame_done <= tick & fd_nxt;
         if (tick) begin
            t        <= t_nxt;
            scan_idx <= idx_nxt;
            snap     <= snap_nxt;
            LEDSEL   <= sel_nxt;
            LEDOUT   <= out_nxt;
         end
      end
   end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: directed bench for disp_scan_ctrl.
// Edge-indexed stimulus, hand-computed expectations.
module tb_disp_scan_ctrl;

   logic       clk;
   logic       rst;
   logic [7:0] digit0;
   logic [7:0] digit1;
   logic [7:0] digit2;
   logic [7:0] digit3;
   logic [3:0] digit_en;
   logic [3:0] brightness;
   logic [3:0] ledsel;
   logic [7:0] ledout;
   logic [1:0] scan_idx;
   logic       frame_done;
   logic [3:0] d_ledsel;
   logic [7:0] d_ledout;
   logic [1:0] d_idx;
   logic       d_fd;

   int n_cmp  = 0;
   int n_err  = 0;
   int edge_n = 0;
   int fd_cnt = 0;
   int base   = 0;

   disp_scan_ctrl #(.DIV(2), .BLANK_TICKS(1)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .digit0     (digit0),
      .digit1     (digit1),
      .digit2     (digit2),
      .digit3     (digit3),
      .digit_en   (digit_en),
      .brightness (brightness),
      .LEDSEL     (ledsel),
      .LEDOUT     (ledout),
      .scan_idx   (scan_idx),
      .frame_done (frame_done)
   );

   disp_scan_ctrl u_def (
      .clk        (clk),
      .rst        (rst),
      .digit0     (digit0),
      .digit1     (digit1),
      .digit2     (digit2),
      .digit3     (digit3),
      .digit_en   (digit_en),
      .brightness (brightness),
      .LEDSEL     (d_ledsel),
      .LEDOUT     (d_ledout),
      .scan_idx   (d_idx),
      .frame_done (d_fd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counter: frame_done is high for a full clock, seen once per negedge.
   always @(negedge clk) if (frame_done) fd_cnt++;

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic adv(input int e);
      while (edge_n < e) begin
         @(posedge clk);
         edge_n++;
      end
      #1;
   endtask

   initial begin
      rst        = 1'b1;
      digit0     = 8'hC0;
      digit1     = 8'hF9;
      digit2     = 8'hA4;
      digit3     = 8'hB0;
      digit_en   = 4'hF;
      brightness = 4'd15;
      @(posedge clk);
      #1;
      chk("rst_sel", 8'(ledsel), 8'h0F);
      chk("rst_out", ledout, 8'hFF);
      chk("rst_idx", 8'(scan_idx), 8'h00);
      chk("rst_fd", 8'(frame_done), 8'h00);
      @(negedge clk);
      rst    = 1'b0;
      edge_n = 0;

      adv(1);   chk("pre_hold", 8'(ledsel), 8'h0F);
      adv(2);   chk("t1_sel", 8'(ledsel), 8'h0E);
                chk("t1_out", ledout, 8'hFF);
                chk("t1_idx", 8'(scan_idx), 8'h00);
      adv(4);   chk("def_pre4", 8'(d_ledsel), 8'h0F);
      adv(5);   chk("def_tick5", 8'(d_ledsel), 8'h0E);
                chk("def_out5", d_ledout, 8'hFF);

      adv(32);  chk("s1_idx", 8'(scan_idx), 8'h01);
                chk("s1_blank", 8'(ledsel), 8'h0F);
                chk("s1_fd", 8'(frame_done), 8'h00);
      adv(34);  chk("s1_sel", 8'(ledsel), 8'h0D);
                chk("s1_out", ledout, 8'hF9);
      adv(40);  digit1 = 8'h80;
      adv(62);  chk("snap_hold", ledout, 8'hF9);
      adv(64);  chk("s2_idx", 8'(scan_idx), 8'h02);
      adv(66);  chk("s2_sel", 8'(ledsel), 8'h0B);
                chk("s2_out", ledout, 8'hA4);
      adv(96);  chk("s3_idx", 8'(scan_idx), 8'h03);
      adv(98);  chk("s3_sel", 8'(ledsel), 8'h07);
                chk("s3_out", ledout, 8'hB0);
      adv(128); chk("wrap_fd", 8'(frame_done), 8'h01);
                chk("wrap_idx", 8'(scan_idx), 8'h00);
      adv(129); chk("wrap_fd_end", 8'(frame_done), 8'h00);
                base = fd_cnt;
      adv(130); chk("s4_sel", 8'(ledsel), 8'h0E);
                chk("s4_out", ledout, 8'hC0);
      adv(160); chk("s5_idx", 8'(scan_idx), 8'h01);
      adv(162); chk("snap_new", ledout, 8'h80);
                chk("s5_sel", 8'(ledsel), 8'h0D);

      adv(185); brightness = 4'd4;
      adv(192); chk("b4_t0", 8'(ledsel), 8'h0F);
      adv(193); chk("b4_holdtick", 8'(ledsel), 8'h0F);
      adv(194); chk("b4_t1", 8'(ledsel), 8'h0B);
      adv(200); chk("b4_t4", 8'(ledsel), 8'h0B);
                chk("b4_t4_out", ledout, 8'hA4);
      adv(202); chk("b4_t5", 8'(ledsel), 8'h0F);
                chk("b4_t5_out", ledout, 8'hFF);
      adv(210); brightness = 4'd0;
      adv(226); chk("b0_idx", 8'(scan_idx), 8'h03);
                chk("b0_t1", 8'(ledsel), 8'h0F);
      adv(240); chk("b0_t8", 8'(ledsel), 8'h0F);
      adv(250); brightness = 4'd15;
      adv(257); chk("fd_per_frame", 8'(fd_cnt - base), 8'h01);
                chk("s8_idx", 8'(scan_idx), 8'h00);

      adv(260); digit_en = 4'b0101;
      adv(288); chk("sk_idx2", 8'(scan_idx), 8'h02);
                chk("sk_fd0", 8'(frame_done), 8'h00);
      adv(320); chk("sk_idx0", 8'(scan_idx), 8'h00);
                chk("sk_fd1", 8'(frame_done), 8'h01);
      adv(352); chk("sk_idx2b", 8'(scan_idx), 8'h02);
      adv(384); chk("sk_idx0b", 8'(scan_idx), 8'h00);
                chk("sk_fd1b", 8'(frame_done), 8'h01);
      adv(388); chk("sk_sel0", 8'(ledsel), 8'h0E);
      adv(390); digit_en = 4'b0100;
      adv(392); chk("clr_blank", 8'(ledsel), 8'h0F);
      adv(416); chk("one_idx", 8'(scan_idx), 8'h02);
                chk("one_fd0", 8'(frame_done), 8'h00);
      adv(448); chk("one_idx_b", 8'(scan_idx), 8'h02);
                chk("one_fd1", 8'(frame_done), 8'h01);
      adv(450); chk("one_sel", 8'(ledsel), 8'h0B);
                chk("one_out", ledout, 8'hA4);
      adv(480); chk("one_fd1b", 8'(frame_done), 8'h01);

      adv(490); digit_en = 4'b0000;
      adv(491); base = fd_cnt;
      adv(492); chk("off_sel", 8'(ledsel), 8'h0F);
                chk("off_out", ledout, 8'hFF);
      adv(512); chk("off_idx_a", 8'(scan_idx), 8'h02);
                chk("off_fd", 8'(frame_done), 8'h00);
      adv(544); chk("off_idx_b", 8'(scan_idx), 8'h02);
      adv(576); chk("off_idx_c", 8'(scan_idx), 8'h02);
      adv(590); digit_en = 4'hF;
      adv(600); chk("off_fd_cnt", 8'(fd_cnt - base), 8'h00);
      adv(608); chk("ret_idx", 8'(scan_idx), 8'h03);
                chk("ret_fd", 8'(frame_done), 8'h00);
      adv(610); chk("ret_sel", 8'(ledsel), 8'h07);
                chk("ret_out", ledout, 8'hB0);

      #2;
      rst = 1'b1;
      #1;
      chk("arst_sel", 8'(ledsel), 8'h0F);
      chk("arst_out", ledout, 8'hFF);
      chk("arst_idx", 8'(scan_idx), 8'h00);
      @(posedge clk);
      #1;
      chk("arst_hold", 8'(ledsel), 8'h0F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
Display scan scheduler for the 4-digit 7-segment panel on the FPGA board. It takes four pre-decoded digit patterns from the hex_to_7seg decoders and time-shares the single LEDOUT segment bus between the four LEDSEL anodes. Each digit slot is a fixed 16-tick sequence: a blanking interval for ghost suppression, then a PWM brightness window. Disabled digits are skipped. It sits between the hex decoders and the board pins, in place of a bare scan mux.

Parameters:
DIV, 5, clk cycles per scan tick (>=1)
BLANK_TICKS, 1, ticks blanked at start of each slot (0..15)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
digit0  input  8  segment pattern for digit 0, active-low segments
digit1  input  8  segment pattern for digit 1
digit2  input  8  segment pattern for digit 2
digit3  input  8  segment pattern for digit 3
digit_en  input  4  per-digit enable mask, bit i = digit i
brightness  input  4  on-ticks per slot after blanking, 0 = dark
LEDSEL  output  4  anode select, active-low, at most one bit low
LEDOUT  output  8  segment drive, active-low, 8'hFF = blank
scan_idx  output  2  index of current slot's digit
frame_done  output  1  1-cycle pulse when scan wraps to an earlier or equal index

Behaviour:
- Single clock domain. rst is asynchronous and active-high. All state and outputs are registered.
- Reset values: LEDSEL=4'hF, LEDOUT=8'hFF, scan_idx=0, frame_done=0. Prescaler=0, tick counter t=0, snapshot=8'hFF.
- Prescaler: counts 0..DIV-1. tick=1 for one clk when prescaler==DIV-1, then wraps to 0.
- All state updates, and all sampling of digit_en and brightness, happen only on clk edges where tick=1. Outputs hold between ticks.
- t is a 4-bit slot tick counter. Each slot is 16 ticks.
- Slot end (tick with t==15):
  - t goes to 0.
  - scan_idx advances to the first enabled index in circular order (idx+1, idx+2, idx+3, idx). The current idx is chosen again only if it is the sole enabled digit.
  - The snapshot register loads digit[new idx].
  - frame_done pulses for one clk (the tick edge) if new idx <= old idx.
- Otherwise, on a tick, t increments.
- Drive rule, evaluated on the next-state (idx, t):
  - on = digit_en[idx] && (t >= BLANK_TICKS) && (t - BLANK_TICKS < brightness).
  - If on: LEDSEL = ~(4'b0001 << idx) and LEDOUT = snapshot.
  - Else: LEDSEL=4'hF and LEDOUT=8'hFF.
  - Differences are computed in 5 bits, so there is no wrap. BLANK_TICKS + brightness > 16 saturates at t=15.
- Snapshot isolation: digit inputs changing mid-slot do not affect LEDOUT until the next slot boundary.
- digit_en==0:
  - Outputs stay blank; idx holds; t keeps cycling; frame_done never pulses.
  - When an enable reappears, the next slot end selects it.
- digit_en clearing the current digit mid-slot: blanks immediately at the next tick. The slot still runs to t==15.
- First slot after reset:
  - idx=0 with snapshot 8'hFF.
  - LEDSEL goes low per the drive rule only if digit_en[0], but LEDOUT shows blank.
  - Real data appears from the second slot onward.
- rst asserted mid-slot forces reset values immediately, without waiting for clk.

Test Plan:
- Reset: assert rst between clk edges -> LEDSEL=4'hF, LEDOUT=8'hFF, scan_idx=0 immediately. After release, first tick occurs 5 clks later.
- Full scan (DIV=2, BLANK=1, en=4'hF, bright=15, digits C0/F9/A4/B0):
  - after the first frame, each slot is 32 clks, blank for t=0, then 15 ticks on.
  - LEDSEL sequence 1110,1101,1011,0111 with LEDOUT C0,F9,A4,B0.
  - frame_done pulses once per 128 clks, at entry to slot 0.
- Brightness 4: digit on only for t=1..4 (8 clks); blank for t=5..15. Brightness 0 -> LEDSEL stays 4'hF.
- Skip: en=4'b0101 -> scan_idx 0,2,0,2; frame_done every 2 slots. en=4'b0100 -> idx stays 2; frame_done every slot.
- Snapshot: change digit1 from F9 to 80 mid-slot-1 -> LEDOUT stays F9 until the slot ends; 80 shown on the next visit to idx 1.
- Mask off: en=0 for 3 slots -> outputs blank, no frame_done. Restore en=4'hF -> the next slot end selects idx+1.
